// File: rtl/mem_arb_pkg.sv
// Shared types for the cache/RAM arbiter: FSM states, requester class and bus word types.
package mem_arb_pkg;

    localparam int NCPU_DEF = 2;
    localparam int AW_DEF   = 32;
    localparam int DW_DEF   = 32;

    typedef logic [AW_DEF-1:0] addr_t;
    typedef logic [DW_DEF-1:0] word_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {REQ_I, REQ_D} req_type_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of per-core icache/dcache request lines plus the shared RAM port.
interface cache_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NCPU = NCPU_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
);
    logic [NCPU-1:0]    iREN;
    logic [NCPU*AW-1:0] iaddr;
    logic [NCPU-1:0]    dREN;
    logic [NCPU-1:0]    dWEN;
    logic [NCPU*AW-1:0] daddr;
    logic [NCPU*DW-1:0] dstore;
    logic [NCPU-1:0]    iwait;
    logic [NCPU-1:0]    dwait;
    logic [NCPU*DW-1:0] iload;
    logic [NCPU*DW-1:0] dload;
    logic               ramREN;
    logic               ramWEN;
    logic [AW-1:0]      ramaddr;
    logic [DW-1:0]      ramstore;
    logic [DW-1:0]      ramload;
    logic               ram_rdy;

    // Caches and RAM model side.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Arbiter side.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around; one-hot grant.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);
    logic found;

    // Two passes: positions from ptr upward, then the wrapped positions below ptr.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (!found && c >= int'(ptr) && req[c]) begin
                grant[c] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (!found && c < int'(ptr) && req[c]) begin
                grant[c] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port among the icache/dcache of NCPU cores: dcache first, round-robin within a class,
// IDLE -> ACCESS -> DONE per transfer with a single-cycle wait release.
module cache_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCPU = NCPU_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input logic                CLK,
    input logic                nRST,
    cache_mem_arbiter_if.slave bus
);
    localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;

    arb_state_t      state;
    req_type_t       gtype;
    logic            gwrite;
    logic [CW-1:0]   gcore;
    logic [CW-1:0]   rr_ptr;

    logic [NCPU-1:0] dreq;
    logic [NCPU-1:0] d_grant;
    logic [NCPU-1:0] i_grant;
    logic            d_valid;
    logic            i_valid;
    logic [CW-1:0]   d_idx;
    logic [CW-1:0]   i_idx;
    logic            req_live;
    logic            active;
    logic            done_now;
    int              addr_base;
    int              data_base;

    assign dreq = bus.dREN | bus.dWEN;

    rr_pick #(.N(NCPU), .PW(CW)) u_pick_d (
        .req   (dreq),
        .ptr   (rr_ptr),
        .grant (d_grant),
        .valid (d_valid)
    );

    rr_pick #(.N(NCPU), .PW(CW)) u_pick_i (
        .req   (bus.iREN),
        .ptr   (rr_ptr),
        .grant (i_grant),
        .valid (i_valid)
    );

    always_comb begin
        d_idx = '0;
        i_idx = '0;
        for (int c = 0; c < NCPU; c++) begin
            if (d_grant[c]) d_idx = CW'(c);
            if (i_grant[c]) i_idx = CW'(c);
        end
    end

    // RAM side follows the granted core's live request, so a dropped request aborts at once
    // and an asynchronous reset (state -> IDLE) kills the strobes immediately.
    always_comb begin
        addr_base    = int'(gcore) * AW;
        data_base    = int'(gcore) * DW;
        req_live     = (gtype == REQ_D) ? dreq[gcore] : bus.iREN[gcore];
        active       = (state == ACCESS) && req_live;
        done_now     = active && bus.ram_rdy;
        bus.ramREN   = active && !gwrite;
        bus.ramWEN   = active && gwrite;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        if (active) begin
            bus.ramaddr = (gtype == REQ_D) ? bus.daddr[addr_base +: AW] : bus.iaddr[addr_base +: AW];
            if (gwrite) bus.ramstore = bus.dstore[data_base +: DW];
        end
        if (done_now) begin
            if (gtype == REQ_D) begin
                bus.dwait[gcore] = 1'b0;
                if (!gwrite) bus.dload[data_base +: DW] = bus.ramload;
            end else begin
                bus.iwait[gcore] = 1'b0;
                bus.iload[data_base +: DW] = bus.ramload;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gcore  <= '0;
            gtype  <= REQ_I;
            gwrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_valid) begin
                        gcore  <= d_idx;
                        gtype  <= REQ_D;
                        gwrite <= bus.dWEN[d_idx];
                        state  <= ACCESS;
                    end else if (i_valid) begin
                        gcore  <= i_idx;
                        gtype  <= REQ_I;
                        gwrite <= 1'b0;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!req_live)        state <= IDLE;
                    else if (bus.ram_rdy) state <= DONE;
                end
                DONE: begin
                    rr_ptr <= (gcore == CW'(NCPU - 1)) ? '0 : gcore + CW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
module tb_cache_mem_arbiter;
    localparam int NCPU = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic CLK = 1'b0;
    logic nRST;
    int   vector_count = 0;
    int   miss_count   = 0;

    cache_mem_arbiter_if #(.NCPU(NCPU), .AW(AW), .DW(DW)) bus ();

    cache_mem_arbiter #(.NCPU(NCPU), .AW(AW), .DW(DW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] iren, input logic [1:0] dren,
                                 input logic [1:0] dwen, input logic rdy);
        bus.iREN    = iren;
        bus.dREN    = dren;
        bus.dWEN    = dwen;
        bus.ram_rdy = rdy;
    endtask

    task automatic nextCycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic midCycle;
        @(negedge CLK);
    endtask

    logic [1:0]  rr_dwait [9] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
    logic [31:0] rr_addr  [9] = '{32'h0, 32'h100, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h100, 32'h0};

    initial begin
        nRST        = 1'b0;
        bus.iaddr   = '0;
        bus.daddr   = '0;
        bus.dstore  = '0;
        bus.ramload = '0;
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
        #2;
        checkOutput("rst_iwait",    64'(bus.iwait),    64'(2'b11));
        checkOutput("rst_dwait",    64'(bus.dwait),    64'(2'b11));
        checkOutput("rst_ramREN",   64'(bus.ramREN),   64'(1'b0));
        checkOutput("rst_ramWEN",   64'(bus.ramWEN),   64'(1'b0));
        checkOutput("rst_ramaddr",  64'(bus.ramaddr),  64'h0);
        checkOutput("rst_ramstore", 64'(bus.ramstore), 64'h0);
        checkOutput("rst_iload",    64'(bus.iload),    64'h0);
        checkOutput("rst_dload",    64'(bus.dload),    64'h0);
        nextCycle;
        nextCycle;
        nRST = 1'b1;

        // Both dcaches hammering: core0, core1, core0 with a wait pulse every third cycle.
        bus.daddr   = {32'h200, 32'h100};
        bus.ramload = 32'h1111_1111;
        applyStimulus(2'b00, 2'b11, 2'b00, 1'b1);
        for (int k = 0; k < 9; k++) begin
            midCycle;
            checkOutput($sformatf("rr_dwait_%0d", k), 64'(bus.dwait),   64'(rr_dwait[k]));
            checkOutput($sformatf("rr_addr_%0d", k),  64'(bus.ramaddr), 64'(rr_addr[k]));
            if (k == 1) checkOutput("rr_dload", 64'(bus.dload), {32'h0, 32'h1111_1111});
            nextCycle;
        end

        // Single icache read; ram_rdy already high while IDLE must be ignored.
        bus.iaddr   = {32'h0, 32'h40};
        bus.ramload = 32'hDEAD_BEEF;
        applyStimulus(2'b01, 2'b00, 2'b00, 1'b1);
        midCycle;
        checkOutput("i_idle_iwait",  64'(bus.iwait),  64'(2'b11));
        checkOutput("i_idle_ramREN", 64'(bus.ramREN), 64'(1'b0));
        nextCycle;
        midCycle;
        checkOutput("i_acc_ramREN",  64'(bus.ramREN),  64'(1'b1));
        checkOutput("i_acc_ramWEN",  64'(bus.ramWEN),  64'(1'b0));
        checkOutput("i_acc_ramaddr", 64'(bus.ramaddr), 64'h40);
        checkOutput("i_acc_iwait",   64'(bus.iwait),   64'(2'b10));
        checkOutput("i_acc_iload",   64'(bus.iload),   {32'h0, 32'hDEAD_BEEF});
        nextCycle;
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
        midCycle;
        checkOutput("i_done_iwait",  64'(bus.iwait),  64'(2'b11));
        checkOutput("i_done_iload",  64'(bus.iload),  64'h0);
        checkOutput("i_done_ramREN", 64'(bus.ramREN), 64'(1'b0));
        nextCycle;

        // icache and dcache write from core0 together: write first, icache after the bubble.
        bus.iaddr   = {32'h0, 32'h40};
        bus.daddr   = {32'h200, 32'h80};
        bus.dstore  = {32'h0, 32'h1234_5678};
        bus.ramload = 32'hCAFE_F00D;
        applyStimulus(2'b01, 2'b00, 2'b01, 1'b1);
        nextCycle;
        midCycle;
        checkOutput("w_ramWEN",   64'(bus.ramWEN),   64'(1'b1));
        checkOutput("w_ramREN",   64'(bus.ramREN),   64'(1'b0));
        checkOutput("w_ramaddr",  64'(bus.ramaddr),  64'h80);
        checkOutput("w_ramstore", 64'(bus.ramstore), 64'h1234_5678);
        checkOutput("w_dwait",    64'(bus.dwait),    64'(2'b10));
        checkOutput("w_iwait",    64'(bus.iwait),    64'(2'b11));
        checkOutput("w_dload",    64'(bus.dload),    64'h0);
        nextCycle;
        applyStimulus(2'b01, 2'b00, 2'b00, 1'b1);
        midCycle;
        checkOutput("w_done_iwait",    64'(bus.iwait),    64'(2'b11));
        checkOutput("w_done_ramWEN",   64'(bus.ramWEN),   64'(1'b0));
        checkOutput("w_done_ramstore", 64'(bus.ramstore), 64'h0);
        nextCycle;
        midCycle;
        checkOutput("w_idle_iwait",  64'(bus.iwait),  64'(2'b11));
        checkOutput("w_idle_ramREN", 64'(bus.ramREN), 64'(1'b0));
        nextCycle;
        midCycle;
        checkOutput("w_i_ramREN",  64'(bus.ramREN),  64'(1'b1));
        checkOutput("w_i_ramaddr", 64'(bus.ramaddr), 64'h40);
        checkOutput("w_i_iwait",   64'(bus.iwait),   64'(2'b10));
        checkOutput("w_i_iload",   64'(bus.iload),   {32'h0, 32'hCAFE_F00D});
        nextCycle;
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
        nextCycle;

        // Slow RAM: four ACCESS cycles without ram_rdy, release on the fifth.
        bus.daddr   = {32'h300, 32'h80};
        bus.ramload = 32'h55AA_55AA;
        applyStimulus(2'b00, 2'b10, 2'b00, 1'b0);
        nextCycle;
        for (int k = 0; k < 4; k++) begin
            midCycle;
            checkOutput($sformatf("slow_dwait_%0d", k),  64'(bus.dwait),   64'(2'b11));
            checkOutput($sformatf("slow_ramREN_%0d", k), 64'(bus.ramREN),  64'(1'b1));
            checkOutput($sformatf("slow_addr_%0d", k),   64'(bus.ramaddr), 64'h300);
            nextCycle;
        end
        applyStimulus(2'b00, 2'b10, 2'b00, 1'b1);
        midCycle;
        checkOutput("slow_rel_dwait", 64'(bus.dwait), 64'(2'b01));
        checkOutput("slow_rel_dload", 64'(bus.dload), {32'h55AA_55AA, 32'h0});
        nextCycle;
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
        midCycle;
        checkOutput("slow_done_dwait",  64'(bus.dwait),  64'(2'b11));
        checkOutput("slow_done_ramREN", 64'(bus.ramREN), 64'(1'b0));
        nextCycle;

        // Abort: core0 drops its request mid-ACCESS; rr_ptr must still favour core0 afterwards.
        bus.daddr = {32'h500, 32'h400};
        applyStimulus(2'b00, 2'b01, 2'b00, 1'b0);
        nextCycle;
        midCycle;
        checkOutput("ab_ramREN", 64'(bus.ramREN),  64'(1'b1));
        checkOutput("ab_addr",   64'(bus.ramaddr), 64'h400);
        nextCycle;
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b1);
        midCycle;
        checkOutput("ab_drop_ramREN", 64'(bus.ramREN), 64'(1'b0));
        checkOutput("ab_drop_dwait",  64'(bus.dwait),  64'(2'b11));
        nextCycle;
        applyStimulus(2'b00, 2'b11, 2'b00, 1'b1);
        nextCycle;
        midCycle;
        checkOutput("ab_next_addr",  64'(bus.ramaddr), 64'h400);
        checkOutput("ab_next_dwait", 64'(bus.dwait),   64'(2'b10));
        nextCycle;
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
        nextCycle;

        // Reset pulled mid-ACCESS between edges; afterwards rr_ptr is back at core0.
        applyStimulus(2'b00, 2'b10, 2'b00, 1'b0);
        nextCycle;
        #2;
        checkOutput("ar_pre_ramREN", 64'(bus.ramREN), 64'(1'b1));
        nRST = 1'b0;
        #1;
        checkOutput("ar_ramREN",  64'(bus.ramREN),  64'(1'b0));
        checkOutput("ar_ramWEN",  64'(bus.ramWEN),  64'(1'b0));
        checkOutput("ar_dwait",   64'(bus.dwait),   64'(2'b11));
        checkOutput("ar_iwait",   64'(bus.iwait),   64'(2'b11));
        checkOutput("ar_ramaddr", 64'(bus.ramaddr), 64'h0);
        nextCycle;
        nextCycle;
        applyStimulus(2'b00, 2'b11, 2'b00, 1'b1);
        nRST = 1'b1;
        nextCycle;
        midCycle;
        checkOutput("ar_post_addr",  64'(bus.ramaddr), 64'h400);
        checkOutput("ar_post_dwait", 64'(bus.dwait),   64'(2'b10));
        nextCycle;
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
        nextCycle;
        nextCycle;

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single RAM port between the icache and dcache of NCPU cores.
- Each cache issues word requests with REN/WEN plus an address, and stalls on its wait signal.
- The arbiter grants one requester at a time, drives the RAM, and returns data with a one-cycle wait release.
- Sits between the per-core caches blocks and the RAM model.

Parameters:
- NCPU, 2, number of cores; requester vector width.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  NCPU  icache read request per core.
- iaddr  in  NCPU*AW  icache word address per core.
- dREN  in  NCPU  dcache read request per core.
- dWEN  in  NCPU  dcache write request per core.
- daddr  in  NCPU*AW  dcache address per core.
- dstore  in  NCPU*DW  dcache write data per core.
- iwait  out  NCPU  1 = icache request not complete.
- dwait  out  NCPU  1 = dcache request not complete.
- iload  out  NCPU*DW  icache read data.
- dload  out  NCPU*DW  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ram_rdy  in  1  RAM access completes this cycle.

Behaviour:
Clock and reset:
- One clock domain. Reset is asynchronous and active-low on nRST.
- Reset values: state=IDLE, rr_ptr=0, grant registers cleared, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- Reset values (combinational outputs): iwait=dwait=all 1s, iload=dload=0.

Wait outputs:
- Default wait=1 for every requester, including requesters that are not requesting.
- A wait bit goes low only for the granted requester, only in the cycle ram_rdy=1 in ACCESS.

State machine:
- IDLE: sample the request vectors and pick a winner.
  - Priority: dcache beats icache.
  - Within a class, round-robin: the search starts at core rr_ptr.
  - A winner is registered: gcore, gtype I/D, gwrite = dWEN.
  - dWEN and dREN both high from one core means a write.
  - With no requests, stay in IDLE.
  - The winner is registered, so ACCESS starts one cycle after the request is seen.
- ACCESS:
  - ramaddr, ramstore and ramREN/ramWEN are driven from the granted core's live inputs.
  - When ram_rdy=1, that core's wait drops for exactly this cycle.
  - On a read, the matching load output = ramload in the same cycle.
  - Next state is DONE.
  - If the granted request is deasserted before ram_rdy, abort: strobes drop, no wait pulse, next state IDLE, rr_ptr unchanged.
- DONE:
  - One bubble cycle; strobes are low.
  - rr_ptr advances to (gcore+1) mod NCPU.
  - Next state is IDLE.
  - This guarantees the cache sees wait low for one cycle and can deassert or change its request before re-arbitration.

Latency and throughput:
- Minimum request-to-wait-low is 2 cycles: IDLE, then ACCESS with ram_rdy already high.
- Throughput is one access per 3 cycles minimum.

Load outputs:
- iload/dload for non-granted cores hold 0.
- Caches must latch data on wait low.

Fairness:
- A persistent dcache requester on core 0 cannot starve core 1's dcache, because of rr_ptr.
- icache can be starved only while some dcache request is continuously present (accepted design choice).
- ram_rdy outside ACCESS is ignored.
- Reset asserted during ACCESS: strobes drop asynchronously; the in-flight access is discarded.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, DONE};
  - req_type_t {REQ_I, REQ_D};
  - word_t (DW) and addr_t (AW) typedefs.
- One natural sub-module: rr_pick, a parameterised round-robin priority picker (request vector + pointer -> one-hot grant + valid). It is instantiated twice, once for the dcache class and once for the icache class.

Test Plan:
- Single icache read: iREN[0]=1, iaddr=0x40, ramload=0xDEADBEEF, ram_rdy high from the first ACCESS cycle -> iwait[0] low at cycle 2 only, iload[0]=0xDEADBEEF, ramREN=1 and ramaddr=0x40 during ACCESS.
- I vs D same cycle: iREN[0]=1 and dWEN[0]=1, daddr=0x80, dstore=0x12345678 -> write granted first, ramWEN=1 with ramstore=0x12345678. The icache is granted after DONE; iwait[0] stays 1 throughout the dcache access.
- Round-robin: dREN=2'b11 held continuously with ram_rdy=1 -> grants alternate core0, core1, core0, and dwait pulses alternate every 3 cycles.
- Slow RAM: ram_rdy low for 4 ACCESS cycles -> dwait stays 1 and the strobes stay high for 4 cycles. wait drops on the 5th cycle, and the state passes through DONE.
- Abort: the granted core deasserts dREN mid-ACCESS before ram_rdy -> next state IDLE, no wait pulse, rr_ptr unchanged.
- Async reset during ACCESS: pull nRST low between clock edges -> ramREN/ramWEN go to 0 immediately and all wait bits go to 1. After release, arbitration restarts with rr_ptr=0.
